// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 16-word data memory.
// Port A (CPU load/store) and port B (debug/DMA loader) share one memory; each
// access takes IDLE -> ACCESS -> RESP, with a single-cycle strobe and a single-cycle ack.
module dmem_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [DATA_W-1:0] mem_readData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  state_t              nextState;
  logic                grantA;
  logic                grantB;
  logic                ownerB;
  logic                lastB;
  logic                weReg;
  logic [ADDR_W-1:0]   addrReg;
  logic [DATA_W-1:0]   wdataReg;
  logic [DATA_W-1:0]   aRdataReg;
  logic [DATA_W-1:0]   bRdataReg;
  logic                inRange;

  // Only the upper address bits decide range; the full address still goes to memory.
  assign inRange       = (addrReg[ADDR_W-1:DEPTH_LOG2] == '0);
  assign mem_address   = addrReg;
  assign mem_writeData = wdataReg;
  assign a_rdata       = aRdataReg;
  assign b_rdata       = bRdataReg;

  // Next-state, grant and strobe/ack decode; outputs depend on registered state only.
  always_comb begin
    nextState    = state;
    grantA       = 1'b0;
    grantB       = 1'b0;
    mem_MemWrite = 1'b0;
    mem_MemRead  = 1'b0;
    a_ack        = 1'b0;
    a_err        = 1'b0;
    b_ack        = 1'b0;
    b_err        = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the port that did not go last wins.
        grantA = a_req && (!b_req || lastB);
        grantB = b_req && (!a_req || !lastB);
        if (grantA || grantB) nextState = ACCESS;
      end
      ACCESS: begin
        mem_MemWrite = inRange && weReg;
        mem_MemRead  = inRange && !weReg;
        nextState    = RESP;
      end
      RESP: begin
        a_ack     = !ownerB;
        a_err     = !ownerB && !inRange;
        b_ack     = ownerB;
        b_err     = ownerB && !inRange;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // FSM state register; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Latch the winning request at the grant edge so later input changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ownerB   <= 1'b0;
      lastB    <= 1'b1;
      weReg    <= 1'b0;
      addrReg  <= '0;
      wdataReg <= '0;
    end else if (state == IDLE && (grantA || grantB)) begin
      ownerB   <= grantB;
      lastB    <= grantB;
      weReg    <= grantB ? b_we    : a_we;
      addrReg  <= grantB ? b_addr  : a_addr;
      wdataReg <= grantB ? b_wdata : a_wdata;
    end
  end

  // Capture read data (or clear on error) into the owner's rdata at the end of ACCESS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aRdataReg <= '0;
      bRdataReg <= '0;
    end else if (state == ACCESS) begin
      if (!ownerB) begin
        if (!inRange)    aRdataReg <= '0;
        else if (!weReg) aRdataReg <= mem_readData;
      end else begin
        if (!inRange)    bRdataReg <= '0;
        else if (!weReg) bRdataReg <= mem_readData;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 16-word behavioural memory attached.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] mem_address, mem_writeData, mem_readData;
  logic        mem_MemWrite, mem_MemRead;

  logic [15:0] mem [16];
  int          passCnt = 0;
  int          totalCnt = 0;
  logic [15:0] rdA, rdB;

  typedef struct {
    logic        portB;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        expErr;
    logic [15:0] expRdata;
  } vec_t;
  vec_t vecs [10];

  dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
    .mem_readData(mem_readData)
  );

  always #5 clk = ~clk;

  // Level-sensitive memory: combinational read, write lands at the edge closing the strobe.
  assign mem_readData = mem[mem_address[3:0]];
  always @(posedge clk) if (mem_MemWrite) mem[mem_address[3:0]] <= mem_writeData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idleInputs();
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
  endtask

  // One isolated transaction: grant edge, ACCESS sampled after edge 1, RESP after edge 2.
  task automatic runTxn(input vec_t v, input int idx);
    @(negedge clk);
    if (v.portB) begin
      b_req = 1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
    end else begin
      a_req = 1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d access strobes", idx), {mem_MemWrite, mem_MemRead},
        {v.we && !v.expErr, !v.we && !v.expErr});
    chk($sformatf("v%0d access addr", idx), mem_address, v.addr);
    chk($sformatf("v%0d access acks", idx), {a_ack, b_ack}, 2'b00);
    @(posedge clk); #1;
    chk($sformatf("v%0d resp strobes", idx), {mem_MemWrite, mem_MemRead}, 2'b00);
    chk($sformatf("v%0d resp ack/err", idx), {a_ack, a_err, b_ack, b_err},
        v.portB ? {2'b00, 1'b1, v.expErr} : {1'b1, v.expErr, 2'b00});
    if (v.portB) begin
      chk($sformatf("v%0d b_rdata", idx), b_rdata, v.expRdata);
      chk($sformatf("v%0d a_rdata kept", idx), a_rdata, rdA);
      rdB = v.expRdata;
    end else begin
      chk($sformatf("v%0d a_rdata", idx), a_rdata, v.expRdata);
      chk($sformatf("v%0d b_rdata kept", idx), b_rdata, rdB);
      rdA = v.expRdata;
    end
    idleInputs();
    @(posedge clk); #1;
    chk($sformatf("v%0d idle acks", idx), {a_ack, b_ack, mem_MemWrite, mem_MemRead}, 4'b0000);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    vecs[0] = '{1'b1, 1'b1, 16'h0003, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 16'h0002, 16'h000F, 1'b0, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'h000F};
    vecs[4] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 16'h0000};
    vecs[6] = '{1'b0, 1'b0, 16'h000F, 16'h0000, 1'b0, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'hBEEF};
    vecs[8] = '{1'b1, 1'b1, 16'h000F, 16'hA5A5, 1'b0, 16'hBEEF};
    vecs[9] = '{1'b0, 1'b0, 16'h000F, 16'h0000, 1'b0, 16'hA5A5};

    idleInputs();
    rdA = 16'h0000; rdB = 16'h0000;
    reset_n = 0;
    #12;
    chk("reset outputs", {a_ack, a_err, b_ack, b_err, mem_MemWrite, mem_MemRead}, 6'b0);
    chk("reset rdata", {a_rdata, b_rdata}, 32'h0);
    chk("reset mem bus", {mem_address, mem_writeData}, 32'h0);
    @(negedge clk); reset_n = 1;

    for (int i = 0; i < 10; i++) runTxn(vecs[i], i);

    // Continuous contention from reset: A,B,A,B with acks three cycles apart.
    @(negedge clk); reset_n = 0;
    a_req = 1; a_we = 0; a_addr = 16'h0003;
    b_req = 1; b_we = 0; b_addr = 16'h0002;
    @(negedge clk); reset_n = 1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("tie acks cyc%0d", k), {a_ack, b_ack},
          {(k == 2 || k == 8), (k == 5 || k == 11)});
      if (k == 2 || k == 8) chk($sformatf("tie a_rdata cyc%0d", k), a_rdata, 16'hBEEF);
      if (k == 5 || k == 11) chk($sformatf("tie b_rdata cyc%0d", k), b_rdata, 16'h000F);
      if (k == 11) idleInputs();
    end

    // Reset asserted mid-ACCESS: strobe drops at once, no ack follows.
    @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 16'h0004; a_wdata = 16'h1111;
    @(posedge clk); #1;
    chk("rstmid write strobe", mem_MemWrite, 1'b1);
    #2 reset_n = 0;
    #1;
    chk("rstmid strobes async", {mem_MemWrite, mem_MemRead, a_ack, b_ack}, 4'b0000);
    a_we = 0; a_addr = 16'h0003;
    b_req = 1; b_we = 0; b_addr = 16'h0002;
    @(posedge clk); #1;
    chk("rstmid held acks", {a_ack, b_ack}, 2'b00);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    chk("post-rst A wins", {mem_MemRead, mem_address}, {1'b1, 16'h0003});
    @(posedge clk); #1;
    chk("post-rst ack", {a_ack, a_err, b_ack}, 3'b100);
    chk("post-rst a_rdata", a_rdata, 16'hBEEF);
    idleInputs();
    repeat (4) @(posedge clk);

    // Address changed after grant: latched address 3 is still used.
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 16'h0003;
    @(posedge clk); #1;
    a_addr = 16'h0005;
    chk("latched addr", mem_address, 16'h0003);
    @(posedge clk); #1;
    chk("latched ack", a_ack, 1'b1);
    chk("latched rdata", a_rdata, 16'hBEEF);
    idleInputs();
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 16-word x 16-bit level-sensitive data memory.
- Port A is the CPU load/store unit. Port B is the debug/DMA loader.
- The block serialises accesses with round-robin priority and drives the memory's MemWrite/MemRead strobes for exactly one cycle per access.
- It registers read data and returns a one-cycle ack with an error flag for out-of-range addresses.

Parameters:
- DATA_W, 16, data width of memory and requesters.
- ADDR_W, 16, requester/memory address width.
- DEPTH_LOG2, 4, log2 of implemented memory words; valid addresses are 0 to 2**DEPTH_LOG2-1.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- a_req  input  1  port A request; held until a_ack.
- a_we  input  1  port A: 1=write, 0=read.
- a_addr  input  ADDR_W  port A word address.
- a_wdata  input  DATA_W  port A write data.
- a_ack  output  1  port A one-cycle completion pulse.
- a_err  output  1  valid with a_ack; address out of range.
- a_rdata  output  DATA_W  port A read data, valid with a_ack.
- b_req, b_we, b_addr, b_wdata, b_ack, b_err, b_rdata: same as port A, for port B.
- mem_address  output  ADDR_W  to memory address.
- mem_writeData  output  DATA_W  to memory writeData.
- mem_MemWrite  output  1  memory write strobe.
- mem_MemRead  output  1  memory read strobe.
- mem_readData  input  DATA_W  from memory readData.

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE.
  - All acks, errs, strobes = 0; rdata regs = 0; mem_address/mem_writeData = 0.
  - Round-robin pointer last=B, so A wins the first tie.
  - Memory contents are not touched.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Sample a_req/b_req each edge.
  - None asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the port not equal to last.
  - On grant: latch owner, we, addr, wdata into internal regs; set last=owner; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_address and mem_writeData come from the latched regs.
  - Range check: if addr >= 2**DEPTH_LOG2, both strobes stay 0 and err is flagged.
  - In range, write: mem_MemWrite=1, mem_MemRead=0.
  - In range, read: mem_MemRead=1, mem_MemWrite=0; mem_readData is captured into the owner's rdata reg at the closing edge.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - Owner's ack=1.
  - Owner's err=1 if out of range.
  - rdata holds the captured value; writes leave rdata unchanged; errors set rdata=0.
  - Go to IDLE.
  - Requests are ignored in this state.
- Strobes and acks are decoded from registered state only; they never depend combinationally on req inputs.
- Latency: req high in IDLE at edge N → ACCESS cycle N+1 → ack cycle N+2.
  - Throughput: one access per 3 cycles.
- Handshake:
  - Requester holds req, we, addr, wdata stable until it sees ack.
  - Changes after the grant edge are ignored because the request is latched.
  - req still high in the IDLE after RESP is a new transaction, arbitrated normally.
  - Under continuous contention A and B strictly alternate.
- Non-owner ack/err stay 0; non-owner rdata is unchanged.
- Reset mid-operation (ACCESS or RESP): strobes and acks drop immediately, FSM returns to IDLE, the in-flight access is abandoned. A write cut in ACCESS may or may not land; the bench must not check it.
- Width rules:
  - Range check uses addr[ADDR_W-1:DEPTH_LOG2] != 0.
  - mem_address passes the full ADDR_W.

Test Plan:
- Setup: memory word 3 preloaded with 16'hBEEF via port B write. A read addr 3 → mem_MemRead high 1 cycle at N+1; a_ack pulse at N+2 with a_rdata=16'hBEEF, a_err=0.
- Write/read-back: B write addr 2 data 16'h000F → mem_MemWrite exactly 1 cycle, b_ack at N+2. Then A read addr 2 → a_rdata=16'h000F.
- Simultaneous: a_req and b_req both high from reset, held for 4 transactions → grant order A,B,A,B, acks 3 cycles apart, no overlap.
- Out of range: A read addr 16'h0010 → no strobe asserted, a_ack with a_err=1, a_rdata=0. Then B write addr 16'hFFFF → b_err=1, memory unchanged (read addr 15 returns prior value).
- Reset in ACCESS: assert reset_n=0 mid-cycle → strobes 0 asynchronously, no ack. After release, A request completes normally with latency 2 and A wins the tie.
- Stimulus change after grant: change a_addr from 3 to 5 during ACCESS → access still uses addr 3.
